regfile_8x16: RTL

REGFILE_8X16 -- requirements
Module: regfile_8x16

---
 rtl/regfile_8x16_pkg.sv | 12 +
 rtl/regfile_rd_port.sv | 56 +++++
 rtl/regfile_8x16.sv | 89 ++++++++
 3 files changed

// File: rtl/regfile_8x16_pkg.sv
// Shared sizing defaults and word typedefs for the 8x16 register file.
// Also used by the downstream 2:1 mux stage that takes rd0_data/rd1_data.
package regfile_8x16_pkg;

   localparam int RF_DATA_W = 16;
   localparam int RF_DEPTH  = 8;
   localparam int RF_ADDR_W = $clog2(RF_DEPTH);

   typedef logic [RF_DATA_W-1:0] rf_data_t;
   typedef logic [RF_ADDR_W-1:0] rf_addr_t;

endpackage

// File: rtl/regfile_rd_port.sv
// One registered read port: address mux, write bypass, output reg with hold.
// Ports: clk_i, rst_ni, ld_i (accept read), addr_i, mem_i (storage view),
//   wr_en_i/wr_addr_i/wr_data_i (effective write, for bypass), data_o.
//   Macro REGFILE_ZERO_REG_EN forces address 0 to read as zero.
module regfile_rd_port
   import regfile_8x16_pkg::*;
#(
   parameter int DATA_W = RF_DATA_W,
   parameter int DEPTH  = RF_DEPTH,
   parameter int ADDR_W = RF_ADDR_W
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              ld_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [DATA_W-1:0] mem_i [DEPTH],
   input  logic              wr_en_i,
   input  logic [ADDR_W-1:0] wr_addr_i,
   input  logic [DATA_W-1:0] wr_data_i,
   output logic [DATA_W-1:0] data_o
);

   logic [ADDR_W-1:0] idx;
   logic              hit;
   logic              zero;
   logic [DATA_W-1:0] data_d;
   logic [DATA_W-1:0] data_q;

   // Addresses wrap modulo DEPTH.
   assign idx = ADDR_W'(int'(addr_i) % DEPTH);
   // wr_addr_i is already reduced by the top.
   assign hit = wr_en_i && (wr_addr_i == idx);

`ifdef REGFILE_ZERO_REG_EN
   assign zero = (idx == '0);
`else
   assign zero = 1'b0;
`endif

   always_comb begin
      data_d = data_q;
      if (ld_i) begin
         if (zero)     data_d = '0;
         else if (hit) data_d = wr_data_i;
         else          data_d = mem_i[idx];
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) data_q <= '0;
      else         data_q <= data_d;
   end

   assign data_o = data_q;

endmodule

// File: rtl/regfile_8x16.sv
// DEPTH x DATA_W register file, one write port, two 1-cycle read ports.
// Ports: clk, rst_n, wr_en/wr_addr/wr_data, rd_en, rd0_addr, rd1_addr,
//   hold, rd0_data, rd1_data, rd_valid. Macro: REGFILE_ZERO_REG_EN.
module regfile_8x16
   import regfile_8x16_pkg::*;
#(
   parameter int DATA_W = RF_DATA_W,
   parameter int DEPTH  = RF_DEPTH,
   parameter int ADDR_W = RF_ADDR_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd0_addr,
   input  logic [ADDR_W-1:0] rd1_addr,
   input  logic              hold,
   output logic [DATA_W-1:0] rd0_data,
   output logic [DATA_W-1:0] rd1_data,
   output logic              rd_valid
);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [ADDR_W-1:0] widx;
   logic              we;
   logic              ld;
   logic              rd_valid_q;

   assign widx = ADDR_W'(int'(wr_addr) % DEPTH);

`ifdef REGFILE_ZERO_REG_EN
   // Register 0 is hardwired: its writes are dropped, so no bypass either.
   assign we = wr_en && (widx != '0);
`else
   assign we = wr_en;
`endif

   assign ld = rd_en && !hold;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (we) begin
         mem_q[widx] <= wr_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     rd_valid_q <= 1'b0;
      else if (!hold) rd_valid_q <= rd_en;
   end

   regfile_rd_port #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_rd0 (
      .clk_i     (clk),
      .rst_ni    (rst_n),
      .ld_i      (ld),
      .addr_i    (rd0_addr),
      .mem_i     (mem_q),
      .wr_en_i   (we),
      .wr_addr_i (widx),
      .wr_data_i (wr_data),
      .data_o    (rd0_data)
   );

   regfile_rd_port #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_rd1 (
      .clk_i     (clk),
      .rst_ni    (rst_n),
      .ld_i      (ld),
      .addr_i    (rd1_addr),
      .mem_i     (mem_q),
      .wr_en_i   (we),
      .wr_addr_i (widx),
      .wr_data_i (wr_data),
      .data_o    (rd1_data)
   );

   assign rd_valid = rd_valid_q;

endmodule
